// File: rtl/uart_tx_ctrl.sv
// UART transmit engine draining a FIFO: start bit, LSB-first data, optional
// parity, one or two stop bits. Single clock domain (r_clk).
module uart_tx_ctrl #(
  parameter int FIFO_WIDTH = 8,
  parameter int DIV_WIDTH  = 16
) (
  input  logic                  r_clk,
  input  logic                  r_rst,
  input  logic                  tx_en,
  input  logic [DIV_WIDTH-1:0]  baud_div,
  input  logic                  parity_en,
  input  logic                  parity_odd,
  input  logic                  stop2,
  input  logic                  fifo_is_empty,
  input  logic [FIFO_WIDTH-1:0] fifo_r_data,
  output logic                  fifo_r_en,
  output logic                  tx,
  output logic                  tx_busy,
  output logic                  frame_done
);

  localparam int BCW = $clog2(FIFO_WIDTH) + 1;
  localparam logic [BCW-1:0]       LAST_BIT  = BCW'(FIFO_WIDTH - 1);
  localparam logic [BCW-1:0]       BIT_ONE   = BCW'(1);
  localparam logic [DIV_WIDTH-1:0] BAUD_ONE  = DIV_WIDTH'(1);

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_LOAD, S_START, S_DATA, S_PARITY, S_STOP
  } state_t;

  state_t                r_state;
  logic [FIFO_WIDTH-1:0] r_shift;
  logic [BCW-1:0]        r_bit_cnt;
  logic [DIV_WIDTH-1:0]  r_baud_cnt;
  logic [DIV_WIDTH-1:0]  r_div;
  logic                  r_par_en;
  logic                  r_par_bit;
  logic                  r_stop2;
  logic                  r_tx;

  logic                  w_bit_end;
  logic                  w_last_stop;
  logic                  w_fetch_ok;
  logic [FIFO_WIDTH-1:0] w_shifted;

  assign w_bit_end   = (r_baud_cnt == r_div);
  assign w_fetch_ok  = tx_en && !fifo_is_empty;
  assign w_shifted   = r_shift >> 1;
  // The bit counter doubles as the stop-bit index while in STOP.
  assign w_last_stop = (r_state == S_STOP) && w_bit_end &&
                       (r_bit_cnt == {{(BCW-1){1'b0}}, r_stop2});

  always_ff @(posedge r_clk) begin
    if (r_rst) begin
      r_state    <= S_IDLE;
      r_shift    <= '0;
      r_bit_cnt  <= '0;
      r_baud_cnt <= '0;
      r_div      <= '0;
      r_par_en   <= 1'b0;
      r_par_bit  <= 1'b0;
      r_stop2    <= 1'b0;
      r_tx       <= 1'b1;
    end else begin
      r_baud_cnt <= w_bit_end ? '0 : r_baud_cnt + BAUD_ONE;
      case (r_state)
        S_IDLE: begin
          r_baud_cnt <= '0;
          r_tx       <= 1'b1;
          if (w_fetch_ok) r_state <= S_FETCH;
        end
        S_FETCH: begin
          r_baud_cnt <= '0;
          r_state    <= S_LOAD;
        end
        S_LOAD: begin
          r_shift    <= fifo_r_data;
          r_div      <= baud_div;
          r_par_en   <= parity_en;
          r_par_bit  <= (^fifo_r_data) ^ parity_odd;
          r_stop2    <= stop2;
          r_bit_cnt  <= '0;
          r_baud_cnt <= '0;
          r_tx       <= 1'b0;
          r_state    <= S_START;
        end
        S_START: begin
          if (w_bit_end) begin
            r_tx    <= r_shift[0];
            r_state <= S_DATA;
          end
        end
        S_DATA: begin
          if (w_bit_end) begin
            if (r_bit_cnt == LAST_BIT) begin
              r_bit_cnt <= '0;
              if (r_par_en) begin
                r_tx    <= r_par_bit;
                r_state <= S_PARITY;
              end else begin
                r_tx    <= 1'b1;
                r_state <= S_STOP;
              end
            end else begin
              r_shift   <= w_shifted;
              r_tx      <= w_shifted[0];
              r_bit_cnt <= r_bit_cnt + BIT_ONE;
            end
          end
        end
        S_PARITY: begin
          if (w_bit_end) begin
            r_tx      <= 1'b1;
            r_bit_cnt <= '0;
            r_state   <= S_STOP;
          end
        end
        S_STOP: begin
          r_tx <= 1'b1;
          if (w_bit_end) begin
            if (w_last_stop) begin
              r_bit_cnt <= '0;
              r_state   <= w_fetch_ok ? S_FETCH : S_IDLE;
            end else begin
              r_bit_cnt <= r_bit_cnt + BIT_ONE;
            end
          end
        end
        default: begin
          r_tx    <= 1'b1;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign fifo_r_en  = (r_state == S_FETCH);
  assign tx         = r_tx;
  assign tx_busy    = (r_state != S_IDLE);
  assign frame_done = w_last_stop;

endmodule

// File: tb/tb_uart_tx_ctrl.sv
// Bench for uart_tx_ctrl: FIFO model, expected-frame scoreboard and a serial
// monitor that checks every cycle of every frame.
module tb_uart_tx_ctrl;

  logic        r_clk = 1'b0;
  logic        r_rst = 1'b1;
  logic        tx_en = 1'b0;
  logic [15:0] baud_div = 16'd3;
  logic        parity_en = 1'b0;
  logic        parity_odd = 1'b0;
  logic        stop2 = 1'b0;
  logic        fifo_is_empty;
  logic [7:0]  fifo_r_data = 8'h00;
  logic        fifo_r_en;
  logic        tx;
  logic        tx_busy;
  logic        frame_done;

  uart_tx_ctrl #(.FIFO_WIDTH(8), .DIV_WIDTH(16)) dut (
    .r_clk(r_clk), .r_rst(r_rst), .tx_en(tx_en), .baud_div(baud_div),
    .parity_en(parity_en), .parity_odd(parity_odd), .stop2(stop2),
    .fifo_is_empty(fifo_is_empty), .fifo_r_data(fifo_r_data),
    .fifo_r_en(fifo_r_en), .tx(tx), .tx_busy(tx_busy), .frame_done(frame_done)
  );

  always #5 r_clk = ~r_clk;

  // FIFO model: array written by the stimulus, popped here on fifo_r_en.
  logic [7:0] fq [0:63];
  int wr_ptr = 0;
  int rd_ptr = 0;
  assign fifo_is_empty = (rd_ptr == wr_ptr);

  always @(posedge r_clk) begin
    if (fifo_r_en) begin
      fifo_r_data <= fq[rd_ptr];
      rd_ptr      <= rd_ptr + 1;
    end
  end

  typedef struct {
    logic [11:0] bits;
    int          nbits;
    int          div;
  } frame_t;

  frame_t exp_q [0:63];
  int exp_wr = 0;
  int exp_rd = 0;

  int vectors = 0;
  int errors  = 0;

  int     cyc = 0;
  bit     mon_active = 0;
  int     mon_bi = 0;
  int     mon_ci = 0;
  frame_t cur;
  int     st_cyc = 0, last_end = 0, last_gap = 0, last_len = 0;
  int     ren_count = 0, last_ren = 0, prev_ren = 0, fd_count = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s @cyc %0d: got %0d, expected %0d", tag, cyc, obs, exp);
    end
  endtask

  task automatic add_exp(input logic [7:0] d, input int div);
    frame_t f;
    int n;
    f.bits = 12'hFFF;
    f.bits[0] = 1'b0;
    for (int i = 0; i < 8; i++) f.bits[i+1] = d[i];
    n = 9;
    if (parity_en) begin
      f.bits[n] = (^d) ^ parity_odd;
      n++;
    end
    n += stop2 ? 2 : 1;
    f.nbits = n;
    f.div = div;
    exp_q[exp_wr] = f;
    exp_wr++;
  endtask

  task automatic push_byte(input logic [7:0] d, input bit with_exp, input int div);
    fq[wr_ptr] = d;
    wr_ptr++;
    if (with_exp) add_exp(d, div);
  endtask

  task automatic monitor_step();
    bit last;
    cyc++;
    if (frame_done) fd_count++;
    if (fifo_r_en) begin
      ren_count++;
      prev_ren = last_ren;
      last_ren = cyc;
      check("ren_while_empty", fifo_is_empty, 0);
    end
    if (r_rst) begin
      mon_active = 0;
      return;
    end
    if (!mon_active) begin
      check("frame_done_idle", frame_done, 0);
      if (tx == 1'b0) begin
        check("start_expected", exp_wr != exp_rd, 1);
        if (exp_wr != exp_rd) begin
          cur = exp_q[exp_rd];
          exp_rd++;
          mon_active = 1;
          mon_bi = 0;
          mon_ci = 0;
          st_cyc = cyc;
          last_gap = cyc - last_end - 1;
        end
      end
    end
    if (mon_active) begin
      last = (mon_bi == cur.nbits - 1) && (mon_ci == cur.div);
      check($sformatf("tx_bit%0d", mon_bi), tx, cur.bits[mon_bi]);
      check("tx_busy", tx_busy, 1);
      check("frame_done", frame_done, last);
      if (last) begin
        mon_active = 0;
        last_end = cyc;
        last_len = cyc - st_cyc + 1;
        $display("frame done: %0d bits, %0d cycles, gap %0d", cur.nbits, last_len, last_gap);
      end else if (mon_ci == cur.div) begin
        mon_ci = 0;
        mon_bi++;
      end else begin
        mon_ci++;
      end
    end
  endtask

  task automatic tick();
    @(negedge r_clk);
    monitor_step();
  endtask

  task automatic wait_idle(input string tag, input int budget);
    bit done = 0;
    for (int i = 0; i < budget && !done; i++) begin
      tick();
      if (!mon_active && exp_rd == exp_wr && !tx_busy) done = 1;
    end
    if (!done) check({"timeout_", tag}, 0, 1);
  endtask

  task automatic wait_bit(input string tag, input int target, input int budget);
    bit done = 0;
    for (int i = 0; i < budget && !done; i++) begin
      tick();
      if (mon_active && mon_bi == target) done = 1;
    end
    if (!done) check({"timeout_", tag}, 0, 1);
  endtask

  initial begin
    int r0, f0;
    repeat (3) tick();
    check("rst_tx", tx, 1);
    check("rst_busy", tx_busy, 0);
    check("rst_ren", fifo_r_en, 0);
    check("rst_done", frame_done, 0);
    r_rst = 1'b0;
    tick();

    // Single 8N1 frame, divisor 3
    tx_en = 1'b1;
    push_byte(8'hA5, 1, 3);
    wait_idle("single", 200);
    check("single_len", last_len, 40);
    check("single_ren", ren_count, 1);
    check("single_done", fd_count, 1);
    check("ren_to_start", st_cyc - last_ren, 2);

    // Parity even / odd, then two stop bits
    parity_en = 1'b1;
    parity_odd = 1'b0;
    push_byte(8'hA5, 1, 3);
    wait_idle("par_even", 200);
    check("par_even_len", last_len, 44);
    parity_odd = 1'b1;
    push_byte(8'hA5, 1, 3);
    wait_idle("par_odd", 200);
    check("par_odd_len", last_len, 44);
    stop2 = 1'b1;
    push_byte(8'hA5, 1, 3);
    wait_idle("stop2", 200);
    check("stop2_len", last_len, 48);

    // Back-to-back 0x00 then 0xFF
    parity_en = 1'b0;
    parity_odd = 1'b0;
    stop2 = 1'b0;
    r0 = ren_count;
    push_byte(8'h00, 1, 3);
    push_byte(8'hFF, 1, 3);
    wait_idle("b2b", 300);
    check("b2b_ren_count", ren_count - r0, 2);
    check("b2b_ren_spacing", last_ren - prev_ren, 42);
    check("b2b_tx_gap", last_gap, 2);

    // Empty FIFO with tx_en high
    r0 = ren_count;
    for (int i = 0; i < 100; i++) begin
      tick();
      check("empty_tx", tx, 1);
    end
    check("empty_ren", ren_count, r0);
    check("empty_busy", tx_busy, 0);

    // tx_en dropped during data bit 2 with a second byte waiting
    r0 = ren_count;
    f0 = fd_count;
    push_byte(8'h3C, 1, 3);
    push_byte(8'h5A, 0, 3);
    wait_bit("dis_bit2", 3, 100);
    tx_en = 1'b0;
    wait_idle("dis", 200);
    repeat (60) tick();
    check("dis_ren", ren_count - r0, 1);
    check("dis_done", fd_count - f0, 1);
    add_exp(8'h5A, 3);
    tx_en = 1'b1;
    wait_idle("reenable", 200);
    check("reenable_ren", ren_count - r0, 2);

    // Reset during data bit 3
    push_byte(8'hC3, 1, 3);
    wait_bit("rst_bit3", 4, 100);
    r_rst = 1'b1;
    tick();
    check("midrst_tx", tx, 1);
    check("midrst_busy", tx_busy, 0);
    r_rst = 1'b0;
    r0 = ren_count;
    repeat (50) tick();
    check("midrst_no_reread", ren_count, r0);
    push_byte(8'h96, 1, 3);
    wait_idle("after_rst", 200);
    check("after_rst_ren", ren_count - r0, 1);

    // Divisor change 3->7 during DATA of the first of two frames
    push_byte(8'h11, 1, 3);
    push_byte(8'h22, 1, 7);
    wait_bit("cfg_data", 2, 100);
    baud_div = 16'd7;
    wait_idle("cfg", 400);
    check("cfg_len2", last_len, 80);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule

// File: doc/uart_tx_ctrl.md
# uart_tx_ctrl

UART transmit engine on the read side of `UartFiFo`. It pops bytes from the FIFO whenever data is available and transmission is enabled, then serialises each byte onto `tx`. Frame format: start bit, data LSB-first, optional parity, one or two stop bits. It runs entirely in the FIFO read clock domain and drives the FIFO's `r_en`, using its `r_data` and `is_empty`.

## Interface
- `FIFO_WIDTH`, default 8: data bits per frame; must equal the FIFO data width.
- `DIV_WIDTH`, default 16: width of the baud divisor port.
- `r_clk` input, 1 bit: FIFO read clock. Sole clock of the block.
- `r_rst` input, 1 bit: reset, synchronous, active-high.
- `tx_en` input, 1 bit: enable fetching new frames. A frame in progress always completes.
- `baud_div` input, `DIV_WIDTH` bits: each bit lasts `baud_div+1` clock cycles.
- `parity_en` input, 1 bit: append a parity bit.
- `parity_odd` input, 1 bit: 1 selects odd parity, 0 selects even.
- `stop2` input, 1 bit: 1 sends two stop bits, 0 sends one.
- `fifo_is_empty` input, 1 bit: FIFO `is_empty`.
- `fifo_r_data` input, `FIFO_WIDTH` bits: FIFO `r_data`, registered, valid the cycle after `fifo_r_en`.
- `fifo_r_en` output, 1 bit: FIFO read strobe, a single-cycle pulse.
- `tx` output, 1 bit: serial line, registered, idles high.
- `tx_busy` output, 1 bit: high in every state other than IDLE.
- `frame_done` output, 1 bit: one-cycle pulse in the last cycle of the final stop bit.

## Operation
- **States:** IDLE, FETCH, LOAD, START, DATA, PARITY, STOP.
- **IDLE:** If `tx_en && !fifo_is_empty`, go to FETCH. Otherwise stay.
- **FETCH:** Exactly one cycle. `fifo_r_en`=1, decoded from the state. Go to LOAD.
- **LOAD:** One cycle.
  - Capture `fifo_r_data` into the shift register.
  - Latch `baud_div`, `parity_en`, `parity_odd`, `stop2`. Config changes after LOAD do not affect the current frame.
  - Clear the bit counter and baud counter. Go to START.
- **Baud counter:** Counts 0..`baud_div_latched`. A bit ends when count == divisor. `baud_div`=0 gives one cycle per bit.
- **START:** `tx`=0 for one bit time, then go to DATA.
- **DATA:** Shift out LSB first for `FIFO_WIDTH` bit times, then go to PARITY if `parity_en`, else STOP.
- **PARITY:** Value = XOR of data bits, XOR `parity_odd`. One bit time, then go to STOP.
- **STOP:** `tx`=1 for one bit time, or two if `stop2`. At the end, pulse `frame_done`, then:
  - if `tx_en && !fifo_is_empty`, go to FETCH;
  - otherwise go to IDLE.
- **`tx` register:** Loaded each cycle from the next-state bit value, so `tx` changes in the first cycle of each bit. `tx`=1 in IDLE, FETCH and LOAD.
- **`tx_en` low mid-frame:** The frame finishes normally, then the block returns to IDLE with no further `fifo_r_en`.
- **`fifo_is_empty`:** Sampled only in IDLE and at the end of STOP. No read is ever issued while `fifo_is_empty`=1.

## Timing
- **Reset values:** `tx`=1, `tx_busy`=0, `fifo_r_en`=0, `frame_done`=0, state IDLE, counters 0.
- **Reset mid-frame:** On the cycle after `r_rst` is sampled high, `tx`=1 and the state is IDLE. The partial byte is discarded and not re-read.
- **Latency to start bit:** With the condition true at IDLE in cycle N:
  - `fifo_r_en` is high in cycle N+1;
  - `tx` falls in cycle N+3.
- **Frame length** in cycles is (`baud_div`+1) × (1 + `FIFO_WIDTH` + `parity_en` + 1 + `stop2`).
- **Back-to-back frames:** FETCH→FETCH spacing is frame length + 2 cycles. `tx` stays high for 2 cycles between frames (FETCH, LOAD).
- **Bit counter** is `$clog2(FIFO_WIDTH)+1` bits wide. The baud counter is `DIV_WIDTH` bits and never wraps past the divisor.

## Test plan
- **Single frame:** `baud_div`=3, 8N1, FIFO holds 0xA5.
  - `tx` = 0,1,0,1,0,0,1,0,1,1, each level held 4 cycles.
  - 40-cycle frame, one `frame_done`, one `fifo_r_en`.
- **Parity:** 0xA5 with `parity_en`=1.
  - `parity_odd`=0 gives parity bit 0; `parity_odd`=1 gives 1.
  - Frame is 44 cycles. With `stop2`=1, frame is 48 cycles.
- **Back-to-back:** `baud_div`=3, 8N1, FIFO holds 0x00 then 0xFF.
  - `fifo_r_en` pulses exactly 42 cycles apart.
  - `tx` high for exactly 2 cycles between the frames.
- **Empty FIFO / disable:**
  - `fifo_is_empty`=1 with `tx_en`=1 for 100 cycles: no `fifo_r_en`, `tx`=1.
  - `tx_en` dropped during data bit 2: the frame completes and no second read occurs.
- **Reset mid-frame:** `r_rst` pulsed during data bit 3.
  - Next cycle: `tx`=1, `tx_busy`=0.
  - After release: a fresh frame, with new `fifo_r_en`, starts only if data is present.
- **Config change mid-frame:** `baud_div` changed 3→7 during DATA.
  - The current frame keeps 4-cycle bits; the next frame uses 8-cycle bits.
